// File: rtl/ga25_obj_list.sv
// GA25 object list front end: frame-start DMA of the CPU object table into a
// double-banked shadow list, and a per-line scan that presents one object per
// slot on obj_in with the renderer's phase strobes on obj_sel.
//
//   state    | meaning
//   DMA_IDLE | no copy started since reset
//   DMA_COPY | copying words into the non-displayed bank
//   DMA_DONE | copy complete; next vpulse swaps banks
module ga25_obj_list #(
  parameter int MAX_OBJ  = 128,
  parameter int SLOT_LEN = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         hpulse,
  input  logic                         vpulse,
  input  logic [7:0]                   obj_count,
  output logic [$clog2(MAX_OBJ)+1:0]   dma_addr,
  input  logic [15:0]                  dma_data,
  output logic [47:0]                  obj_in,
  output logic [2:0]                   obj_sel,
  output logic                         busy
);

  localparam int AW = $clog2(MAX_OBJ) + 2;
  localparam int CW = $clog2(MAX_OBJ) + 1;
  localparam int WW = CW + 2;
  localparam int SW = $clog2(SLOT_LEN);
  localparam logic [8:0] MAX_CNT = 9'(MAX_OBJ);

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_COPY = 2'd1,
    DMA_DONE = 2'd2
  } dma_state_t;

  dma_state_t dma_state, dma_state_nxt;
  logic dma_done, dma_we;

  logic [WW-1:0] wcnt, wcnt_inc, dma_total;
  logic [CW-1:0] dma_count, dma_count_clamp;
  logic [CW-1:0] scan_count, scan_count_nxt;
  logic [CW-1:0] idx, idx_inc;
  logic [SW-1:0] cyc;
  logic          disp_bank, bank_nxt, swap;
  logic [8:0]    obj_count_ext;

  logic [15:0] shadow [0:2*MAX_OBJ*4-1];
  logic [15:0] rd_q, w0, w1;
  logic [9:0]  w2;
  logic [AW:0] wr_addr, rd_addr;

  assign obj_count_ext   = {1'b0, obj_count};
  assign dma_count_clamp = CW'((obj_count_ext > MAX_CNT) ? MAX_CNT : obj_count_ext);
  assign dma_total       = {dma_count, 2'b00};
  assign wcnt_inc        = wcnt + 1'b1;
  assign idx_inc         = idx + 1'b1;

  // A completed copy becomes the displayed list at the next frame start.
  assign swap           = ce & vpulse & dma_done;
  assign bank_nxt       = disp_bank ^ swap;
  assign scan_count_nxt = swap ? dma_count : scan_count;

  // DMA always fills the bank that is not on display.
  assign wr_addr = {~disp_bank, wcnt[AW-1:0]};
  // A new line reads entry 0 of the bank that will be displayed after this ce.
  assign rd_addr = (ce & hpulse) ? {bank_nxt, {(CW-1){1'b0}}, 2'b00}
                                 : {disp_bank, idx[CW-2:0], cyc[1:0]};

  // DMA state register
  always_ff @(posedge clk) begin
    if (reset)   dma_state <= DMA_IDLE;
    else if (ce) dma_state <= dma_state_nxt;
  end

  // DMA next state: vpulse (re)starts the copy, aborting any copy in flight
  always_comb begin
    dma_state_nxt = dma_state;
    if (vpulse)
      dma_state_nxt = DMA_COPY;
    else if (dma_state == DMA_COPY && wcnt == dma_total)
      dma_state_nxt = DMA_DONE;
  end

  // DMA outputs: done flag and shadow write enable
  always_comb begin
    dma_done = (dma_state == DMA_DONE);
    dma_we   = ce & ~vpulse & (dma_state == DMA_COPY) & (wcnt < dma_total);
  end

  // DMA word counter and CPU RAM address; data lags the address by one ce
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt      <= '0;
      dma_addr  <= '0;
      dma_count <= '0;
    end else if (ce && vpulse) begin
      wcnt      <= '0;
      dma_addr  <= '0;
      dma_count <= dma_count_clamp;
    end else if (ce && dma_state == DMA_COPY && wcnt != dma_total) begin
      wcnt <= wcnt_inc;
      if (wcnt_inc < dma_total) dma_addr <= wcnt_inc[AW-1:0];
    end
  end

  // Shadow list RAM: DMA write port, scan read port with one ce latency
  always_ff @(posedge clk) begin
    if (dma_we) shadow[wr_addr] <= dma_data;
    if (ce)     rd_q <= shadow[rd_addr];
  end

  // Bank swap, line scan slot sequencing and registered renderer outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_bank  <= 1'b0;
      scan_count <= '0;
      idx        <= '0;
      cyc        <= '0;
      busy       <= 1'b0;
      obj_sel    <= 3'b000;
      obj_in     <= '0;
      w0         <= '0;
      w1         <= '0;
      w2         <= '0;
    end else if (ce) begin
      disp_bank  <= bank_nxt;
      scan_count <= scan_count_nxt;
      obj_sel    <= 3'b000;
      if (hpulse) begin
        // this ce is slot 0 cycle 0: the w0 read has already been issued
        idx  <= '0;
        cyc  <= SW'(1);
        busy <= (scan_count_nxt != '0);
      end else if (busy) begin
        if (cyc == SW'(1)) w0 <= rd_q;
        if (cyc == SW'(2)) w1 <= rd_q;
        if (cyc == SW'(3)) w2 <= rd_q[9:0];
        if (cyc == SW'(4)) begin
          obj_in  <= {6'b0, w2, w1, w0};
          obj_sel <= 3'b010;
        end
        if (cyc == SW'(5)) obj_sel <= 3'b100;
        if (cyc == SW'(SLOT_LEN-1)) begin
          obj_sel <= 3'b001;
          cyc     <= '0;
          idx     <= idx_inc;
          if (idx_inc >= scan_count) busy <= 1'b0;
        end else begin
          cyc <= cyc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ga25_obj_list.sv
// Bench for ga25_obj_list: list-level reference model (CPU table snapshots,
// displayed/pending lists) feeding an expected-strobe queue that a separate
// monitor drains every ce.
module tb_ga25_obj_list;

  localparam int MAX_OBJ  = 128;
  localparam int SLOT_LEN = 8;

  logic        clk = 1'b0;
  logic        reset, ce, hpulse, vpulse;
  logic [7:0]  obj_count;
  logic [8:0]  dma_addr;
  logic [15:0] dma_data;
  logic [47:0] obj_in;
  logic [2:0]  obj_sel;
  logic        busy;

  always #5 clk = ~clk;

  ga25_obj_list #(.MAX_OBJ(MAX_OBJ), .SLOT_LEN(SLOT_LEN)) dut (
    .clk(clk), .reset(reset), .ce(ce), .hpulse(hpulse), .vpulse(vpulse),
    .obj_count(obj_count), .dma_addr(dma_addr), .dma_data(dma_data),
    .obj_in(obj_in), .obj_sel(obj_sel), .busy(busy)
  );

  logic [15:0] cpu_ram [0:4*MAX_OBJ-1];
  assign dma_data = cpu_ram[dma_addr];

  typedef struct {
    int          n;
    logic [2:0]  sel;
    logic [47:0] obj;
  } ev_t;
  ev_t q[$];

  int n_checks = 0, n_fail = 0;
  int ce_n = 0, mon_n = 0;
  bit gap_en = 0;

  logic [47:0] disp_list [0:MAX_OBJ-1];
  logic [47:0] pend_list [0:MAX_OBJ-1];
  int disp_n = 0, pend_n = 0, dma_start = 0;
  bit dma_started = 0;
  int b_start = 1, b_end = 0;

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (ce %0d)", name, got, exp, ce_n);
    end
  endtask

  task automatic fill_cpu_ram();
    for (int i = 0; i < 4*MAX_OBJ; i++) cpu_ram[i] = 16'($urandom);
  endtask

  // Frame start: a copy that ran its full 4N+1 ce before this ce is swapped in.
  task automatic model_frame();
    int oc;
    if (dma_started && (ce_n - dma_start) >= 4*pend_n + 2) begin
      for (int i = 0; i < MAX_OBJ; i++) disp_list[i] = pend_list[i];
      disp_n = pend_n;
    end
    oc = int'(obj_count);
    pend_n = (oc > MAX_OBJ) ? MAX_OBJ : oc;
    for (int i = 0; i < pend_n; i++)
      pend_list[i] = {6'b0, cpu_ram[4*i+2][9:0], cpu_ram[4*i+1], cpu_ram[4*i]};
    dma_start   = ce_n;
    dma_started = 1;
  endtask

  // Line start: drop the abandoned scan's strobes, schedule one slot per entry.
  task automatic model_line();
    int h;
    h = ce_n;
    while (q.size() > 0 && q[$].n >= h) void'(q.pop_back());
    b_start = h;
    b_end   = h + SLOT_LEN*disp_n - 1;
    for (int k = 0; k < disp_n; k++) begin
      q.push_back('{n: h + SLOT_LEN*k + 4,          sel: 3'b010, obj: disp_list[k]});
      q.push_back('{n: h + SLOT_LEN*k + 5,          sel: 3'b100, obj: 48'h0});
      q.push_back('{n: h + SLOT_LEN*k + SLOT_LEN-1, sel: 3'b001, obj: 48'h0});
    end
  endtask

  task automatic step(input bit h, input bit v);
    int gaps;
    gaps = (gap_en && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    repeat (gaps) begin
      @(negedge clk);
      ce = 1'b0; hpulse = 1'($urandom); vpulse = 1'($urandom);
    end
    @(negedge clk);
    ce = 1'b1; hpulse = h; vpulse = v;
    @(posedge clk);
    ce_n++;
    if (v) model_frame();
    if (h) model_line();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ce = 1'b1; hpulse = 1'b1; vpulse = 1'b1;
    @(posedge clk);
    #1 chk("sel_in_reset", 48'(obj_sel), 48'h0);
    @(negedge clk);
    q.delete();
    disp_n = 0; pend_n = 0; dma_started = 0; b_start = 1; b_end = 0;
    reset = 1'b0; ce = 1'b0; hpulse = 1'b0; vpulse = 1'b0;
    #1;
    chk("rst_obj_sel", 48'(obj_sel), 48'h0);
    chk("rst_obj_in", obj_in, 48'h0);
    chk("rst_dma_addr", 48'(dma_addr), 48'h0);
    chk("rst_busy", 48'(busy), 48'h0);
  endtask

  // Monitor: on every ce, compare strobes, obj_in, busy and dma_addr.
  initial begin
    logic [47:0] exp_obj;
    bit had_ce, exp_busy;
    int k, exp_addr;
    exp_obj = '0;
    forever begin
      @(posedge clk);
      had_ce = ce && !reset;
      if (reset) exp_obj = '0;
      #1;
      if (had_ce) begin
        mon_n++;
        if (q.size() > 0 && q[0].n == mon_n) begin
          chk("obj_sel", 48'(obj_sel), 48'(q[0].sel));
          if (q[0].sel == 3'b010) exp_obj = q[0].obj;
          void'(q.pop_front());
        end else begin
          chk("obj_sel_idle", 48'(obj_sel), 48'h0);
        end
        chk("obj_in", obj_in, exp_obj);
        exp_busy = (mon_n >= b_start) && (mon_n < b_end);
        chk("busy", 48'(busy), 48'(exp_busy));
        if (!dma_started || pend_n == 0) exp_addr = 0;
        else begin
          k = mon_n - dma_start;
          exp_addr = (k < 4*pend_n - 1) ? k : 4*pend_n - 1;
        end
        chk("dma_addr", 48'(dma_addr), 48'(exp_addr));
      end
    end
  end

  initial begin
    int len, oc;
    bit v;
    reset = 1'b0; ce = 1'b0; hpulse = 1'b0; vpulse = 1'b0; obj_count = 8'd0;
    fill_cpu_ram();
    do_reset();

    // three-entry copy; no strobes possible until it is swapped in
    cpu_ram[0] = 16'h1234; cpu_ram[1] = 16'hABCD; cpu_ram[2] = 16'h0205;
    obj_count = 8'd3;
    step(1'b0, 1'b1);
    run(20);
    chk("dma_addr_last", 48'(dma_addr), 48'd11);
    step(1'b1, 1'b0);
    run(10);

    // swap in the three-entry list, start a clamped 200-entry copy
    fill_cpu_ram();
    obj_count = 8'd200;
    step(1'b0, 1'b1);
    run(5);
    step(1'b1, 1'b0);
    run(4);
    chk("entry0_obj_in", obj_in, 48'h0205_ABCD_1234);
    chk("entry0_sel", 48'(obj_sel), 48'h2);
    run(26);

    // full 128-entry line
    run(520);
    gap_en = 1;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    run(SLOT_LEN*MAX_OBJ + 10);
    gap_en = 0;

    // hpulse at slot 2 cycle 3 abandons the scan
    step(1'b1, 1'b0);
    run(18);
    step(1'b1, 1'b0);
    run(SLOT_LEN*3 + 10);

    // aborted copy: no swap, address restarts
    fill_cpu_ram();
    obj_count = 8'd100;
    step(1'b0, 1'b1);
    run(100);
    chk("dma_addr_mid", 48'(dma_addr), 48'd100);
    fill_cpu_ram();
    step(1'b0, 1'b1);
    chk("dma_addr_restart", 48'(dma_addr), 48'd0);
    step(1'b1, 1'b0);
    run(SLOT_LEN*MAX_OBJ + 4);
    run(410);

    // simultaneous hpulse and vpulse after a completed copy
    step(1'b1, 1'b1);
    chk("hv_sel", 48'(obj_sel), 48'h0);
    run(SLOT_LEN*100 + 10);

    // randomized lines
    gap_en = 1;
    for (int i = 0; i < 25; i++) begin
      v = 1'($urandom);
      if (v) begin
        fill_cpu_ram();
        case ($urandom_range(0, 3))
          0:       oc = 0;
          1:       oc = int'($urandom_range(1, 6));
          2:       oc = int'($urandom_range(0, 255));
          default: oc = int'($urandom_range(129, 255));
        endcase
        obj_count = 8'(oc);
      end
      case ($urandom_range(0, 3))
        0:       len = int'($urandom_range(5, 40));
        3:       len = SLOT_LEN*MAX_OBJ + 20;
        default: len = int'($urandom_range(40, 300));
      endcase
      step(1'b1, v);
      run(len);
    end
    gap_en = 0;

    // reset in the middle of a scan
    step(1'b1, 1'b0);
    run(30);
    do_reset();
    obj_count = 8'd5;
    step(1'b0, 1'b1);
    run(25);
    step(1'b0, 1'b1);
    run(3);
    step(1'b1, 1'b0);
    run(SLOT_LEN*5 + 10);

    chk("queue_empty", 48'(q.size()), 48'h0);
    @(negedge clk);
    ce = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
